rpn_operand_stack: RTL and testbench
====================================

Name: rpn_operand_stack

Overview:
- Operand stack for the 8-bit RPN ALU; sits directly upstream of the ALU.
- Captures typed operands and holds them in a LIFO stack.
- Presents the top two entries as ALU operands.
- Writes the ALU result back in place of those two entries, so RPN expressions chain without external bookkeeping.

Parameters:
WIDTH, 8, data width of each stack entry and of DATA_IN/RESULT/TOP/NEXT
DEPTH, 4, number of stack entries (legal range 2..16)
CW, $clog2(DEPTH+1), width of COUNT (3 for DEPTH=4)

Ports:
CLOCK  input  1  single system clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
CLEAR  input  1  synchronous stack clear, highest priority
PUSH  input  1  push DATA_IN onto stack
POP  input  1  discard top entry
EXEC  input  1  replace top two entries with RESULT
DATA_IN  input  WIDTH  operand to push
RESULT  input  WIDTH  ALU result, combinational function of TOP/NEXT
TOP  output  WIDTH  entry[COUNT-1] (ALU operand B); 0 when COUNT=0
NEXT  output  WIDTH  entry[COUNT-2] (ALU operand A); 0 when COUNT<2
COUNT  output  CW  number of valid entries, 0..DEPTH
EMPTY  output  1  COUNT==0
FULL  output  1  COUNT==DEPTH
ERROR  output  1  sticky fault flag

Behaviour:
- RESET low (async, regardless of CLOCK):
  - all entries=0, COUNT=0, ERROR=0
  - hence TOP=0, NEXT=0, EMPTY=1, FULL=0
  - Release is sampled on the next rising edge; no command takes effect in the cycle RESET is low.
- Storage: DEPTH registers of WIDTH bits, each with its own load enable; entry[0] is the bottom.
- Outputs:
  - TOP, NEXT, EMPTY and FULL are combinational decodes of the registered COUNT and entries.
  - They reflect a command's effect immediately after the edge that executes it (1-cycle latency from command to visible state).
- Commands are level-sampled at each rising edge; one command per cycle.
- Priority and legality, evaluated per edge:
  1. CLEAR=1: COUNT=0, ERROR=0. Entries are left unchanged (they are unobservable). All other commands are ignored, with no error.
  2. More than one of PUSH/POP/EXEC high: illegal. ERROR=1; stack unchanged.
  3. PUSH:
     - If COUNT<DEPTH: entry[COUNT]=DATA_IN, COUNT+1.
     - Else overflow: ERROR=1, stack unchanged.
  4. POP:
     - If COUNT>=1: COUNT-1; the entry value is kept but no longer visible.
     - Else underflow: ERROR=1.
  5. EXEC:
     - If COUNT>=2: entry[COUNT-2]=RESULT, COUNT-1.
     - Else underflow: ERROR=1, stack unchanged.
  6. No command: hold.
- ERROR is sticky. Only CLEAR or RESET deassert it. Legal commands still execute normally while ERROR=1.
- EXEC when FULL is legal and frees one slot.
- RESULT is sampled at the EXEC edge. It must be stable at setup time, as a combinational function of TOP/NEXT of the same cycle; no internal feedback loop is created.
- Arithmetic: no width growth. RESULT is stored as given, and overflow semantics belong to the ALU.
- RESET asserted mid-command: the command is lost and the stack returns to the reset state.

Test Plan:
1. Reset then release: RESET=0 for 2 cycles with PUSH=1, DATA_IN=8'hAA -> COUNT=0, EMPTY=1, TOP=0, ERROR=0 throughout. After release, first PUSH yields TOP=8'hAA, COUNT=1.
2. Push and EXEC: PUSH 8'h05, PUSH 8'h03 -> NEXT=8'h05, TOP=8'h03, COUNT=2. Then EXEC with RESULT=8'h08 (bench ALU adds) -> TOP=8'h08, NEXT=0, COUNT=1, ERROR=0.
3. Fill and overflow: push 1,2,3,4 -> FULL=1, TOP=4, NEXT=3. Push 8'h99 -> ERROR=1, COUNT=4, TOP=4 unchanged. EXEC with RESULT=8'h07 -> COUNT=3, TOP=7, FULL=0, ERROR still 1.
4. Underflow: from COUNT=1, EXEC -> ERROR=1, COUNT=1. Then POP -> COUNT=0, EMPTY=1. Then POP -> COUNT=0, ERROR=1.
5. Illegal combination: COUNT=2, assert PUSH and POP in the same cycle -> ERROR=1, COUNT=2, TOP/NEXT unchanged.
6. CLEAR priority: COUNT=3, ERROR=1, assert CLEAR with PUSH -> next cycle COUNT=0, ERROR=0, EMPTY=1. Assert RESET low asynchronously mid-cycle after pushing 8'h11 -> outputs drop to reset values before the next edge.

Source files
------------

// File: rtl/rpn_operand_stack_if.sv
// ---------------------------------------------------------------------------
// rpn_operand_stack_if
//
// Purpose:
//   Command/status bundle between the RPN controller (master) and the operand
//   stack (slave). The controller issues one command per cycle and reads the
//   top two entries back as ALU operands. It then feeds the ALU result in on
//   the result lines.
//
// Signals:
//   clear    master->slave  synchronous stack clear, highest priority
//   push     master->slave  push data_in onto the stack
//   pop      master->slave  discard the top entry
//   exec     master->slave  replace the top two entries with result
//   data_in  master->slave  operand to push (WIDTH bits)
//   result   master->slave  ALU result, combinational in top/next (WIDTH bits)
//   top      slave->master  entry[count-1], 0 when the stack is empty
//   next     slave->master  entry[count-2], 0 when count < 2
//   count    slave->master  number of valid entries, 0..DEPTH (CW bits)
//   empty    slave->master  count == 0
//   full     slave->master  count == DEPTH
//   error    slave->master  sticky fault flag
// ---------------------------------------------------------------------------
interface rpn_operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             clear;
    logic             push;
    logic             pop;
    logic             exec;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             error;

    // Controller side: issues commands and operands, observes stack state.
    modport master (
        output clear, push, pop, exec, data_in, result,
        input  top, next, count, empty, full, error
    );

    // Stack side: consumes commands, presents stack state.
    modport slave (
        input  clear, push, pop, exec, data_in, result,
        output top, next, count, empty, full, error
    );
endinterface

// File: rtl/rpn_operand_stack.sv
// ---------------------------------------------------------------------------
// rpn_operand_stack
//
// Purpose:
//   LIFO operand stack that sits directly upstream of the 8-bit RPN ALU. It
//   captures pushed operands and presents the two topmost entries as ALU
//   operands (next = A, top = B). On exec it writes the ALU result back in
//   place of those two entries, so expressions chain without any external
//   bookkeeping.
//
// Ports:
//   clock  single system clock; all state changes on the rising edge
//   reset  asynchronous, active-low reset (entries, count and error to 0)
//   bus    rpn_operand_stack_if.slave; commands in, stack state out
//
// Notes:
//   - Only one command may take effect per edge. clear beats everything.
//     Any two of push/pop/exec together form an illegal combination. It
//     sets error and leaves the stack untouched.
//   - error is sticky. Only clear or reset lower it, and legal commands keep
//     executing while it is set.
//   - top/next/empty/full are decoded combinationally from the registered
//     count and entries. No path exists from result back to top/next, so the
//     external ALU cannot form a combinational loop through this block.
// ---------------------------------------------------------------------------
module rpn_operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    rpn_operand_stack_if.slave    bus
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             error_reg;
    logic             error_next;

    // Read-side view of the per-entry registers built in the generate loop.
    logic [WIDTH-1:0] entry_value [DEPTH];

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic             illegal_combo;
    logic             is_empty;
    logic             is_full;
    logic             has_two;
    logic             do_push;
    logic             do_pop;
    logic             do_exec;
    logic             fault;
    logic [CW-1:0]    exec_slot;      // index of entry[count-2]
    logic [WIDTH-1:0] write_data;

    assign illegal_combo = (bus.push & bus.pop)
                         | (bus.push & bus.exec)
                         | (bus.pop  & bus.exec);

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CW'(DEPTH));
    assign has_two  = (count_reg >= CW'(2));

    // Legal, executable commands. clear masks everything below it.
    assign do_push = ~bus.clear & ~illegal_combo & bus.push & ~is_full;
    assign do_pop  = ~bus.clear & ~illegal_combo & bus.pop  & ~is_empty;
    assign do_exec = ~bus.clear & ~illegal_combo & bus.exec & has_two;

    // Every way a non-clear edge can go wrong: illegal combination,
    // push into a full stack, pop from an empty stack, exec with fewer
    // than two operands.
    assign fault = ~bus.clear & ( illegal_combo
                                | (bus.push & ~is_full)   == 1'b0 & bus.push
                                | (bus.pop  & is_empty)
                                | (bus.exec & ~has_two) );

    // Only meaningful when do_exec is set (count >= 2), so the subtraction
    // never wraps in that case.
    assign exec_slot  = count_reg - CW'(2);

    // push and exec are mutually exclusive once illegal_combo is excluded,
    // so one shared write port serves both.
    assign write_data = do_exec ? bus.result : bus.data_in;

    // -----------------------------------------------------------------------
    // Next-state for count and the sticky error flag
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        error_next = error_reg;

        if (bus.clear) begin
            count_next = '0;
            error_next = 1'b0;
        end else begin
            if (do_push) begin
                count_next = count_reg + CW'(1);
            end else if (do_pop || do_exec) begin
                // exec consumes two operands and produces one result.
                count_next = count_reg - CW'(1);
            end

            if (fault) begin
                error_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            error_reg <= error_next;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage: one register per slot with its own load enable.
    // A slot loads on push when it is the first free slot (index == count).
    // It also loads on exec when it holds the second operand
    // (index == count-2). The result then lands where operand A was, and the
    // slot that held B becomes free.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            logic             load_en;

            assign load_en = (do_push && (count_reg == CW'(gi)))
                          || (do_exec && (exec_slot == CW'(gi)));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (load_en) begin
                    entry_reg <= write_data;
                end
            end

            assign entry_value[gi] = entry_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Operand decode. Slots above count may still hold stale values after
    // pop/exec/clear. They are hidden here by selecting only the slot that
    // count points at, with 0 as the default.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] top_value;
    logic [WIDTH-1:0] next_value;

    always_comb begin
        top_value  = '0;
        next_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CW'(i + 1)) begin
                top_value = entry_value[i];
            end
        end
        for (int i = 0; i + 2 <= DEPTH; i++) begin
            if (count_reg == CW'(i + 2)) begin
                next_value = entry_value[i];
            end
        end
    end

    assign bus.top   = top_value;
    assign bus.next  = next_value;
    assign bus.count = count_reg;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.error = error_reg;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_rpn_operand_stack
//
// Drives the operand stack with the directed scenarios first, then with
// randomized command traffic. Includes clears, illegal combinations and
// asynchronous resets in the middle of a cycle. After each edge every
// visible output is compared against a queue-based reference model.
// The bench ALU adds the model's top two operands.
// ---------------------------------------------------------------------------
module tb_rpn_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    rpn_operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

    rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: the queue back is the stack top.
    logic [WIDTH-1:0] model_q [$];
    logic             model_err = 1'b0;

    function automatic logic [WIDTH-1:0] model_top();
        if (model_q.size() >= 1) return model_q[model_q.size() - 1];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] model_next();
        if (model_q.size() >= 2) return model_q[model_q.size() - 2];
        return '0;
    endfunction

    task automatic model_step(input logic clr, input logic pu, input logic po,
                              input logic ex, input logic [WIDTH-1:0] din,
                              input logic [WIDTH-1:0] res);
        if (clr) begin
            model_q.delete();
            model_err = 1'b0;
        end else if ((int'(pu) + int'(po) + int'(ex)) > 1) begin
            model_err = 1'b1;
        end else if (pu) begin
            if (model_q.size() < DEPTH) model_q.push_back(din);
            else model_err = 1'b1;
        end else if (po) begin
            if (model_q.size() >= 1) void'(model_q.pop_back());
            else model_err = 1'b1;
        end else if (ex) begin
            if (model_q.size() >= 2) begin
                void'(model_q.pop_back());
                void'(model_q.pop_back());
                model_q.push_back(res);
            end else begin
                model_err = 1'b1;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, " count"}, 32'(bus.count), 32'(model_q.size()));
        check_val({tag, " top"},   32'(bus.top),   32'(model_top()));
        check_val({tag, " next"},  32'(bus.next),  32'(model_next()));
        check_val({tag, " empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
        check_val({tag, " full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
        check_val({tag, " error"}, 32'(bus.error), 32'(model_err));
    endtask

    // One command cycle: drive on the falling edge, let the rising edge
    // execute, then compare 1 time unit later.
    task automatic drive(input string tag, input logic clr, input logic pu,
                         input logic po, input logic ex,
                         input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] res;
        @(negedge clock);
        res         = model_next() + model_top();
        bus.clear   = clr;
        bus.push    = pu;
        bus.pop     = po;
        bus.exec    = ex;
        bus.data_in = din;
        bus.result  = res;
        @(posedge clock);
        model_step(clr, pu, po, ex, din, res);
        #1;
        txn++;
        $display("txn %0d %s: clr=%b push=%b pop=%b exec=%b din=%h res=%h -> count=%0d top=%h next=%h err=%b",
                 txn, tag, clr, pu, po, ex, din, res, bus.count, bus.top, bus.next, bus.error);
        check_state(tag);
    endtask

    task automatic set_idle();
        bus.clear   = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.exec    = 1'b0;
        bus.data_in = '0;
        bus.result  = '0;
    endtask

    // Pull reset low between edges. The outputs must drop before the next
    // edge, and an edge taken while reset is low must change nothing.
    task automatic async_reset(input string tag);
        @(negedge clock);
        set_idle();
        bus.push    = 1'b1;           // pending command that must be lost
        bus.data_in = 8'h5A;
        #2;
        reset = 1'b0;
        model_q.delete();
        model_err = 1'b0;
        #1;
        txn++;
        $display("txn %0d %s: async reset asserted mid-cycle -> count=%0d top=%h err=%b",
                 txn, tag, bus.count, bus.top, bus.error);
        check_state({tag, " mid"});
        @(posedge clock);
        #1;
        check_state({tag, " held"});
        @(negedge clock);
        set_idle();
        reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int               r;

        // 1. Reset held low for two edges with a push pending.
        set_idle();
        bus.push    = 1'b1;
        bus.data_in = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            txn++;
            $display("txn %0d reset_hold: count=%0d top=%h err=%b", txn, bus.count, bus.top, bus.error);
            check_state("reset_hold");
        end
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        drive("first_push", 0, 1, 0, 0, 8'hAA);

        // 2. Push two operands and execute (5 + 3 = 8).
        drive("clr2",  1, 0, 0, 0, 8'h00);
        drive("push5", 0, 1, 0, 0, 8'h05);
        drive("push3", 0, 1, 0, 0, 8'h03);
        drive("exec8", 0, 0, 0, 1, 8'h00);
        check_val("exec8 top literal", 32'(bus.top), 32'h08);

        // 3. Fill, overflow, then exec while full.
        drive("clr3", 1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) drive("fill", 0, 1, 0, 0, 8'(i));
        drive("overflow", 0, 1, 0, 0, 8'h99);
        drive("exec_full", 0, 0, 0, 1, 8'h00);
        check_val("exec_full top literal", 32'(bus.top), 32'h07);

        // 4. Underflow on exec and pop.
        drive("clr4",     1, 0, 0, 0, 8'h00);
        drive("push_one", 0, 1, 0, 0, 8'h42);
        drive("exec_uf",  0, 0, 0, 1, 8'h00);
        drive("pop_last", 0, 0, 1, 0, 8'h00);
        drive("pop_uf",   0, 0, 1, 0, 8'h00);

        // 5. Illegal combination leaves the stack unchanged.
        drive("clr5",     1, 0, 0, 0, 8'h00);
        drive("push_a",   0, 1, 0, 0, 8'h21);
        drive("push_b",   0, 1, 0, 0, 8'h34);
        drive("push_pop", 0, 1, 1, 0, 8'h77);

        // 6. Clear wins over push and drops error; then async reset.
        drive("clr6",   1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) drive("push6", 0, 1, 0, 0, 8'(8'h60 + i));
        drive("pop_exec", 0, 0, 1, 1, 8'h00);
        drive("clr_push", 1, 1, 0, 0, 8'hEE);
        drive("push11",   0, 1, 0, 0, 8'h11);
        async_reset("async6");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 3) begin
                drive("rnd_clr", 1, 1'($urandom), 1'($urandom), 1'($urandom), d);
            end else if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: drive("rnd_multi", 0, 1, 1, 0, d);
                    1: drive("rnd_multi", 0, 1, 0, 1, d);
                    2: drive("rnd_multi", 0, 0, 1, 1, d);
                    default: drive("rnd_multi", 0, 1, 1, 1, d);
                endcase
            end else if (r < 10) begin
                async_reset("rnd_rst");
            end else if (r < 45) begin
                drive("rnd_push", 0, 1, 0, 0, d);
            end else if (r < 65) begin
                drive("rnd_pop", 0, 0, 1, 0, d);
            end else if (r < 90) begin
                drive("rnd_exec", 0, 0, 0, 1, d);
            end else begin
                drive("rnd_idle", 0, 0, 0, 0, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
